// File: rtl/aes_spi_master_if.sv
// Host request/result signals and SPI pins of aes_spi_master.
// The timeout signal exists only when AES_SPI_TIMEOUT_EN is defined.
interface aes_spi_master_if #(
    parameter int K = 128
);
    // start is a one-cycle request taken only while busy is low; result_valid
    // is a one-cycle pulse and result holds its value until the next accepted start.
    logic           start;
    logic [K-1:0]   key;
    logic [127:0]   message;
    logic           sclk;
    logic           mosi;
    logic           ce;
    logic           miso;
    logic           done;
    logic           busy;
    logic [127:0]   result;
    logic           result_valid;
`ifdef AES_SPI_TIMEOUT_EN
    logic           timeout;

    modport master (input  start, key, message, miso, done,
                    output sclk, mosi, ce, busy, result, result_valid, timeout);
    modport slave  (output start, key, message, miso, done,
                    input  sclk, mosi, ce, busy, result, result_valid, timeout);
`else
    modport master (input  start, key, message, miso, done,
                    output sclk, mosi, ce, busy, result, result_valid);
    modport slave  (output start, key, message, miso, done,
                    input  sclk, mosi, ce, busy, result, result_valid);
`endif
endinterface

// File: rtl/aes_spi_master.sv
// SPI master that ships {message,key} to an AES accelerator and reads back the ciphertext.
// Optional AES_SPI_TIMEOUT_EN adds a 16-bit WAIT_DONE watchdog and the timeout pulse.
module aes_spi_master #(
    parameter int K   = 128,
    parameter int DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    aes_spi_master_if.master        bus,
    output logic [2:0]              state_dbg
);
    generate
        if (K != 128 && K != 192 && K != 256) begin : g_bad_k
            $error("aes_spi_master: K must be 128, 192 or 256");
        end
        if (DIV < 1) begin : g_bad_div
            $error("aes_spi_master: DIV must be at least 1");
        end
    endgenerate

    localparam int FW = K + 128;
    localparam int BW = $clog2(FW + 1);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] FRAME_LAST = BW'(FW);
    localparam logic [BW-1:0] READ_LAST  = BW'(127);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_DONE = 3'd2,
        READ      = 3'd3,
        FINISH    = 3'd4
    } state_e;

    state_e         state;
    logic [1:0]     done_sync;
    logic           done_s;
    logic [FW-1:0]  shreg;
    logic [BW-1:0]  bit_cnt;
    logic [PW-1:0]  phase_cnt;
    logic           phase_end;
`ifdef AES_SPI_TIMEOUT_EN
    logic [15:0]    to_cnt;
`endif

    assign done_s    = done_sync[1];
    assign phase_end = (phase_cnt == PHASE_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            done_sync        <= '0;
            shreg            <= '0;
            bit_cnt          <= '0;
            phase_cnt        <= '0;
            bus.sclk         <= 1'b0;
            bus.mosi         <= 1'b0;
            bus.ce           <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
`ifdef AES_SPI_TIMEOUT_EN
            to_cnt           <= '0;
            bus.timeout      <= 1'b0;
`endif
        end else begin
            done_sync        <= {done_sync[0], bus.done};
            bus.result_valid <= 1'b0;
`ifdef AES_SPI_TIMEOUT_EN
            bus.timeout      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start && !bus.busy) begin
                        shreg     <= {bus.message, bus.key};
                        bus.mosi  <= bus.message[127];
                        bus.ce    <= 1'b1;
                        bus.busy  <= 1'b1;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (!phase_end) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end else begin
                        phase_cnt <= '0;
                        if (bus.sclk) begin
                            // Falling edge: present the next frame bit for the following rise.
                            bus.sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            shreg    <= {shreg[FW-2:0], 1'b0};
                            bus.mosi <= shreg[FW-2];
                        end else if (bit_cnt == FRAME_LAST) begin
                            bus.ce   <= 1'b0;
                            bus.mosi <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= WAIT_DONE;
`ifdef AES_SPI_TIMEOUT_EN
                            to_cnt   <= 16'd1;
`endif
                        end else begin
                            bus.sclk <= 1'b1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (done_s) begin
                        phase_cnt <= '0;
                        state     <= READ;
                    end
`ifdef AES_SPI_TIMEOUT_EN
                    // to_cnt counts WAIT_DONE cycles including the current one.
                    else if (to_cnt == 16'hFFFF) begin
                        to_cnt      <= '0;
                        bus.timeout <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                READ: begin
                    if (!phase_end) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end else begin
                        phase_cnt <= '0;
                        if (!bus.sclk) begin
                            bus.sclk     <= 1'b1;
                            shreg[127:0] <= {shreg[126:0], bus.miso};
                        end else begin
                            bus.sclk <= 1'b0;
                            if (bit_cnt == READ_LAST) begin
                                bit_cnt <= '0;
                                state   <= FINISH;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                FINISH: begin
                    bus.result       <= shreg[127:0];
                    bus.result_valid <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: K=128/DIV=2 and K=256/DIV=1 instances with SPI slave models.
// With AES_SPI_TIMEOUT_EN defined the WAIT_DONE watchdog is exercised as well.
`timescale 1ns/1ps
module tb_aes_spi_master;
    localparam int K_A    = 128;
    localparam int DIV_A  = 2;
    localparam int K_B    = 256;
    localparam int DIV_B  = 1;
    localparam int BUDGET = 4000;

    // clock / reset
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_spi_master_if #(.K(K_A)) bus_a();
    aes_spi_master_if #(.K(K_B)) bus_b();
    logic [2:0] state_a, state_b;

    aes_spi_master #(.K(K_A), .DIV(DIV_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.master), .state_dbg(state_a));
    aes_spi_master #(.K(K_B), .DIV(DIV_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.master), .state_dbg(state_b));

    logic         sclk_w[2], ce_w[2], mosi_w[2], valid_w[2], busy_w[2];
    logic [127:0] res_w[2];
    assign sclk_w[0]  = bus_a.sclk;          assign sclk_w[1]  = bus_b.sclk;
    assign ce_w[0]    = bus_a.ce;            assign ce_w[1]    = bus_b.ce;
    assign mosi_w[0]  = bus_a.mosi;          assign mosi_w[1]  = bus_b.mosi;
    assign valid_w[0] = bus_a.result_valid;  assign valid_w[1] = bus_b.result_valid;
    assign busy_w[0]  = bus_a.busy;          assign busy_w[1]  = bus_b.busy;
    assign res_w[0]   = bus_a.result;        assign res_w[1]   = bus_b.result;

    // scoreboard
    logic [383:0] exp_frame_q_a[$], exp_frame_q_b[$];
    logic [127:0] exp_res_q_a[$], exp_res_q_b[$];
    int n_checks = 0;
    int n_errors = 0;
    string names[2] = '{"a", "b"};
    int div_of[2]   = '{DIV_A, DIV_B};
    int fw_of[2]    = '{K_A + 128, K_B + 128};
    int completed[2] = '{0, 0};

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave models and output monitor
    logic [127:0] resp_next[2];
    logic [127:0] miso_sh[2];
    logic [383:0] rx[2];
    logic         prev_sclk[2], prev_ce[2], prev_valid[2];
    int hi_rises[2], lo_rises[2], valid_cnt[2];
    int ce_rise_cyc[2], last_rise_cyc[2], last_fall_cyc[2], ce_fall_cyc[2];
    int per_min[2], per_max[2], first_delay[2];
    assign bus_a.miso = miso_sh[0][127];
    assign bus_b.miso = miso_sh[1][127];

    always @(negedge clk) begin
        logic [383:0] ef;
        logic [127:0] er;
        int per;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                prev_sclk[i]  = 1'b0;
                prev_ce[i]    = 1'b0;
                prev_valid[i] = 1'b0;
            end else begin
                if (ce_w[i] && !prev_ce[i]) begin
                    rx[i] = '0; hi_rises[i] = 0; lo_rises[i] = 0;
                    ce_rise_cyc[i] = cyc; per_min[i] = 1 << 30; per_max[i] = 0;
                    miso_sh[i] = resp_next[i];
                end
                if (sclk_w[i] && !prev_sclk[i]) begin
                    if (ce_w[i]) begin
                        rx[i] = {rx[i][382:0], mosi_w[i]};
                        if (hi_rises[i] == 0) first_delay[i] = cyc - ce_rise_cyc[i];
                        else begin
                            per = cyc - last_rise_cyc[i];
                            if (per < per_min[i]) per_min[i] = per;
                            if (per > per_max[i]) per_max[i] = per;
                        end
                        hi_rises[i]++;
                        last_rise_cyc[i] = cyc;
                    end else begin
                        lo_rises[i]++;
                    end
                end
                if (!sclk_w[i] && prev_sclk[i]) begin
                    last_fall_cyc[i] = cyc;
                    if (!ce_w[i]) miso_sh[i] = {miso_sh[i][126:0], 1'b0};
                end
                if (!ce_w[i] && prev_ce[i]) begin
                    ce_fall_cyc[i] = cyc;
                    check($sformatf("%s_first_rise", names[i]), first_delay[i], div_of[i]);
                    check($sformatf("%s_period_min", names[i]), per_min[i], 2 * div_of[i]);
                    check($sformatf("%s_period_max", names[i]), per_max[i], 2 * div_of[i]);
                    check($sformatf("%s_load_rises", names[i]), hi_rises[i], fw_of[i]);
                    check($sformatf("%s_ce_tail", names[i]), cyc - last_fall_cyc[i], div_of[i]);
                    if ((i == 0 ? exp_frame_q_a.size() : exp_frame_q_b.size()) == 0) begin
                        check($sformatf("%s_frame_extra", names[i]), 1, 0);
                    end else begin
                        ef = (i == 0) ? exp_frame_q_a.pop_front() : exp_frame_q_b.pop_front();
                        check($sformatf("%s_frame", names[i]), rx[i], ef);
                    end
                end
                if (prev_valid[i]) check($sformatf("%s_busy_after", names[i]), busy_w[i], 1'b0);
                if (valid_w[i]) begin
                    valid_cnt[i]++;
                    check($sformatf("%s_busy_valid", names[i]), busy_w[i], 1'b1);
                    check($sformatf("%s_read_rises", names[i]), lo_rises[i], 128);
                    if ((i == 0 ? exp_res_q_a.size() : exp_res_q_b.size()) == 0) begin
                        check($sformatf("%s_result_extra", names[i]), 1, 0);
                    end else begin
                        er = (i == 0) ? exp_res_q_a.pop_front() : exp_res_q_b.pop_front();
                        check($sformatf("%s_result", names[i]), res_w[i], er);
                    end
                end
                prev_sclk[i]  = sclk_w[i];
                prev_ce[i]    = ce_w[i];
                prev_valid[i] = valid_w[i];
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pulse_start(input int i, input logic [127:0] msg, input logic [255:0] key);
        if (i == 0) begin
            bus_a.message = msg; bus_a.key = key[127:0]; bus_a.start = 1'b1;
        end else begin
            bus_b.message = msg; bus_b.key = key; bus_b.start = 1'b1;
        end
        tick();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic set_done(input int i, input logic v);
        if (i == 0) bus_a.done = v;
        else        bus_b.done = v;
    endtask

    task automatic wait_rises(input int i, input bit hi, input int target);
        int n = 0;
        while (((hi ? hi_rises[i] : lo_rises[i]) < target) && n < BUDGET) begin
            tick();
            n++;
        end
        check($sformatf("%s_reach_%s%0d", names[i], hi ? "hi" : "lo", target),
              ((hi ? hi_rises[i] : lo_rises[i]) >= target), 1'b1);
    endtask

    task automatic wait_ce_low(input int i);
        int n = 0;
        while (ce_w[i] !== 1'b0 && n < BUDGET) begin
            tick();
            n++;
        end
        check($sformatf("%s_load_end", names[i]), ce_w[i], 1'b0);
    endtask

    task automatic run_txn(input int i, input logic [127:0] msg, input logic [255:0] key,
                           input logic [127:0] resp, input bit early, input bit extra);
        int n;
        int v0;
        v0 = valid_cnt[i];
        if (i == 0) begin
            exp_frame_q_a.push_back({128'b0, msg, key[127:0]});
            exp_res_q_a.push_back(resp);
        end else begin
            exp_frame_q_b.push_back({msg, key});
            exp_res_q_b.push_back(resp);
        end
        resp_next[i] = resp;
        pulse_start(i, msg, key);
        if (extra) begin
            wait_rises(i, 1'b1, 40);
            pulse_start(i, ~msg, ~key);
        end
        if (early) begin
            wait_rises(i, 1'b1, 60);
            set_done(i, 1'b1);
        end
        wait_ce_low(i);
        if (!early) begin
            repeat ($urandom_range(1, 6)) tick();
            set_done(i, 1'b1);
        end
        if (extra) begin
            wait_rises(i, 1'b0, 20);
            pulse_start(i, ~msg, ~key);
        end
        n = 0;
        while (valid_cnt[i] == v0 && n < BUDGET) begin
            tick();
            n++;
        end
        check($sformatf("%s_valid_seen", names[i]), valid_cnt[i] - v0, 1);
        set_done(i, 1'b0);
        completed[i]++;
        repeat (5) tick();
        check($sformatf("%s_result_hold", names[i]), res_w[i], resp);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_a_sclk"},   bus_a.sclk, 1'b0);
        check({pfx, "_a_mosi"},   bus_a.mosi, 1'b0);
        check({pfx, "_a_ce"},     bus_a.ce, 1'b0);
        check({pfx, "_a_busy"},   bus_a.busy, 1'b0);
        check({pfx, "_a_result"}, bus_a.result, 128'b0);
        check({pfx, "_a_valid"},  bus_a.result_valid, 1'b0);
        check({pfx, "_a_state"},  state_a, 3'd0);
        check({pfx, "_b_sclk"},   bus_b.sclk, 1'b0);
        check({pfx, "_b_ce"},     bus_b.ce, 1'b0);
        check({pfx, "_b_busy"},   bus_b.busy, 1'b0);
        check({pfx, "_b_result"}, bus_b.result, 128'b0);
        check({pfx, "_b_valid"},  bus_b.result_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] m, r, prev_res;
        logic [255:0] k;
        int n, c0, v0;
        bus_a.start = 1'b0; bus_a.done = 1'b0; bus_a.message = '0; bus_a.key = '0;
        bus_b.start = 1'b0; bus_b.done = 1'b0; bus_b.message = '0; bus_b.key = '0;
        resp_next[0] = '0; resp_next[1] = '0;
        miso_sh[0] = '0;   miso_sh[1] = '0;
        valid_cnt[0] = 0;  valid_cnt[1] = 0;
        hi_rises[0] = 0;   hi_rises[1] = 0;
        lo_rises[0] = 0;   lo_rises[1] = 0;

        repeat (3) tick();
        check_idle_outputs("rst");
        reset_n = 1'b1;
        repeat (2) tick();

        // FIPS-197 C.1 vector through the K=128, DIV=2 instance
        run_txn(0, 128'h00112233445566778899aabbccddeeff,
                {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0);

        // K=256, DIV=1 frame capture
        run_txn(1, rand128(), {rand128(), rand128()}, rand128(), 1'b0, 1'b0);

        // early done during LOAD plus ignored starts in LOAD and READ
        run_txn(0, rand128(), {128'b0, rand128()}, rand128(), 1'b1, 1'b1);
        run_txn(1, rand128(), {rand128(), rand128()}, rand128(), 1'b0, 1'b1);

        // reset at bit 100 of LOAD
        resp_next[0] = rand128();
        pulse_start(0, rand128(), {128'b0, rand128()});
        wait_rises(0, 1'b1, 100);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        run_txn(0, rand128(), {128'b0, rand128()}, rand128(), 1'b0, 1'b0);

`ifdef AES_SPI_TIMEOUT_EN
        // done never arrives: watchdog must fire
        m = rand128();
        k = {128'b0, rand128()};
        exp_frame_q_a.push_back({128'b0, m, k[127:0]});
        resp_next[0] = rand128();
        prev_res = bus_a.result;
        v0 = valid_cnt[0];
        pulse_start(0, m, k);
        wait_ce_low(0);
        c0 = ce_fall_cyc[0];
        n = 0;
        while (bus_a.timeout !== 1'b1 && n < 70000) begin
            tick();
            n++;
        end
        check("a_timeout_seen", bus_a.timeout, 1'b1);
        check("a_timeout_delay", cyc - c0, 65535);
        check("a_timeout_busy", bus_a.busy, 1'b0);
        check("a_timeout_valid", bus_a.result_valid, 1'b0);
        check("a_timeout_result", bus_a.result, prev_res);
        tick();
        check("a_timeout_pulse", bus_a.timeout, 1'b0);
        repeat (4) tick();
        check("a_timeout_no_valid", valid_cnt[0], v0);
`endif

        repeat (20) tick();
        check("a_valid_count", valid_cnt[0], completed[0]);
        check("b_valid_count", valid_cnt[1], completed[1]);
        check("a_frame_q_empty", exp_frame_q_a.size(), 0);
        check("b_frame_q_empty", exp_frame_q_b.size(), 0);
        check("a_res_q_empty", exp_res_q_a.size(), 0);
        check("b_res_q_empty", exp_res_q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_spi_master.md
AES_SPI_MASTER -- requirements
Module: aes_spi_master

Interface
REQ-001 Parameter K, default 128: key length in bits; legal values are 128, 192 and 256, and any other value SHALL fail elaboration.
REQ-002 Parameter DIV, default 4: SPI half-period in clk cycles; legal values are DIV >= 1.
REQ-003 clk  in  1  the single system clock; all flops SHALL be on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a transaction.
REQ-006 key  in  K  encryption key; SHALL be captured when start is accepted.
REQ-007 message  in  128  plaintext; SHALL be captured when start is accepted.
REQ-008 sclk  out  1  SPI clock to the accelerator; idles low.
REQ-009 mosi  out  1  serial data to the accelerator.
REQ-010 ce  out  1  load/chip-enable to the accelerator; high while shifting in.
REQ-011 miso  in  1  serial result from the accelerator.
REQ-012 done  in  1  accelerator completion flag; asynchronous to clk.
REQ-013 busy  out  1  high from the accepted start until the cycle after result_valid.
REQ-014 result  out  128  ciphertext; held stable until the next accepted start.
REQ-015 result_valid  out  1  one-cycle pulse when result is updated.

Function
REQ-016 done SHALL pass through a 2-flop synchronizer; all uses of done SHALL take the synchronized version.
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_DONE, READ and FINISH.
REQ-018 IDLE: a start with busy low SHALL capture {message,key} into a (K+128)-bit shift register, set ce high and move to LOAD.
- start while busy is high SHALL be ignored.
REQ-019 sclk: each phase SHALL last DIV clk cycles, giving a period of 2*DIV cycles; the first rising edge SHALL come DIV cycles after ce rises.
REQ-020 LOAD: transmission SHALL be MSB-first, beginning with message[127] and ending with key[0].
- mosi SHALL be valid DIV cycles before each sclk rise and change only while sclk is low.
- Exactly K+128 rising edges SHALL be issued.
REQ-021 After the last falling edge, ce SHALL drop DIV cycles later and the FSM SHALL enter WAIT_DONE.
REQ-022 WAIT_DONE: sclk SHALL stay low; the FSM SHALL move to READ on the first cycle synchronized done is high.
REQ-023 READ: exactly 128 sclk pulses SHALL be issued, with the same timing as LOAD and ce held low.
- miso SHALL be sampled on the clk cycle in which sclk rises.
- Samples SHALL shift in MSB-first, so the first bit lands in result[127].
REQ-024 FINISH: result SHALL load from the shift register, result_valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE with busy low in the next cycle.
REQ-025 Bit and phase counters SHALL wrap only via an explicit reload; no counter may roll over implicitly.
REQ-026 A done input that is already high in LOAD SHALL be ignored until WAIT_DONE.

Reset
REQ-027 While reset_n is low, every output SHALL be driven as follows: sclk=0, mosi=0, ce=0, busy=0, result=0, result_valid=0.
- The FSM SHALL be in IDLE, and the counters and synchronizer SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abort it immediately; result SHALL clear and no result_valid SHALL be issued.

Configuration
REQ-029 Macro AES_SPI_TIMEOUT_EN, when defined, SHALL add port timeout (out, 1) and a 16-bit WAIT_DONE counter.
- When the counter reaches 65535, the FSM SHALL go to IDLE and pulse timeout for one cycle.
- In that case result SHALL stay unchanged and result_valid SHALL stay low.
REQ-030 When AES_SPI_TIMEOUT_EN is undefined, the timeout port and counter SHALL be absent and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-031 K=128, DIV=2, and a slave model returning FIPS-197 C.1 are applied: key=000102..0f, message=00112233..ff.
- Required: result=69c4e0d86a7b0430d8cdb78070b4c55a.
- Required: 256 sclk pulses while ce is high and 128 while ce is low.
REQ-032 K=256, DIV=1: the bench SHALL capture mosi on each sclk rise.
- Required: exactly 384 bits, equal to {message,key} MSB-first.
- Required: sclk period of 2 clk cycles.
REQ-033 A second start pulse is applied during LOAD and during READ.
- Required: it is ignored, and the transaction completes with one result_valid.
REQ-034 reset_n is pulled low at bit 100 of LOAD.
- Required: all outputs are 0 on the same cycle.
- Required: a new start afterwards completes normally.
REQ-035 With AES_SPI_TIMEOUT_EN defined, done is held low.
- Required: timeout pulses exactly 65535 cycles after WAIT_DONE is entered.
- Required: busy drops and result_valid stays 0.
